// File: rtl/gate_sequencer.sv
// N-channel gate sequencer: thermometer ramp-up, reverse ramp-down, each step gated on sync feedback.
// Optional sync-timeout fault detection is built when GATE_SYNC_TIMEOUT_EN is defined.
module gate_sequencer #(
   parameter int N_CH         = 5,
   parameter int CNT_W        = 32,
   parameter int SYNC_TIMEOUT = 1024
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [CNT_W-1:0] shift_i,
   input  logic [N_CH-1:0]  gate_sync_i,
   output logic [N_CH-1:0]  gate_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [N_CH-1:0]  EN_ZERO  = {N_CH{1'b0}};
   localparam logic [N_CH-1:0]  EN_ONES  = {N_CH{1'b1}};

   if (N_CH < 2 || SYNC_TIMEOUT < 1) begin : g_param_check
      $error("gate_sequencer: N_CH must be >= 2 and SYNC_TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      RUN       = 3'd2,
      RAMP_DOWN = 3'd3
`ifdef GATE_SYNC_TIMEOUT_EN
      , FAULT   = 3'd4
`endif
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [N_CH-1:0]  gate_en;
   logic [N_CH-1:0]  gate_en_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] shift_q;
   logic [CNT_W-1:0] shift_n;
   logic             match;
   logic             busy;
   logic             done;
   logic             err;
   logic             busy_n;
   logic             done_n;
   logic             err_n;

`ifdef GATE_SYNC_TIMEOUT_EN
   localparam int             MM_W   = $clog2(SYNC_TIMEOUT + 1);
   localparam logic [MM_W-1:0] MM_ZERO = {MM_W{1'b0}};
   localparam logic [MM_W-1:0] MM_ONE  = {{(MM_W-1){1'b0}}, 1'b1};
   localparam logic [MM_W-1:0] MM_MAX  = MM_W'(SYNC_TIMEOUT);

   logic [MM_W-1:0] mm_cnt;
   logic [MM_W-1:0] mm_cnt_n;
   logic            active;
`endif

   // Next-state, next-enable and counter logic.
   always_comb begin
      state_n   = state;
      gate_en_n = gate_en;
      cnt_n     = cnt;
      shift_n   = shift_q;
      match     = (gate_sync_i == gate_en);
      cnt_inc   = (cnt == CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);

      case (state)
         IDLE: begin
            gate_en_n = EN_ZERO;
            cnt_n     = CNT_ZERO;
            if (start_i && !stop_i) begin
               shift_n = shift_i;
               state_n = RAMP_UP;
            end else begin
               state_n = IDLE;
            end
         end
         RAMP_UP: begin
            if (stop_i) begin
               cnt_n   = CNT_ZERO;
               state_n = RAMP_DOWN;
            end else if ((&gate_en) && (&gate_sync_i)) begin
               cnt_n   = CNT_ZERO;
               state_n = RUN;
            end else if (match) begin
               if (cnt == shift_q) begin
                  gate_en_n = {gate_en[N_CH-2:0], 1'b1};
                  cnt_n     = CNT_ZERO;
               end else begin
                  cnt_n = cnt_inc;
               end
            end else begin
               cnt_n = CNT_ZERO;
            end
         end
         RUN: begin
            gate_en_n = EN_ONES;
            if (stop_i) begin
               cnt_n   = CNT_ZERO;
               state_n = RAMP_DOWN;
            end else begin
               state_n = RUN;
            end
         end
         RAMP_DOWN: begin
            if ((gate_en == EN_ZERO) && (gate_sync_i == EN_ZERO)) begin
               cnt_n   = CNT_ZERO;
               state_n = IDLE;
            end else if (match) begin
               if (cnt == shift_q) begin
                  gate_en_n = gate_en >> 1;
                  cnt_n     = CNT_ZERO;
               end else begin
                  cnt_n = cnt_inc;
               end
            end else begin
               cnt_n = CNT_ZERO;
            end
         end
`ifdef GATE_SYNC_TIMEOUT_EN
         FAULT: begin
            gate_en_n = EN_ZERO;
            cnt_n     = CNT_ZERO;
            if (stop_i) begin
               state_n = IDLE;
            end else begin
               state_n = FAULT;
            end
         end
`endif
         default: begin
            state_n   = IDLE;
            gate_en_n = EN_ZERO;
            cnt_n     = CNT_ZERO;
         end
      endcase

`ifdef GATE_SYNC_TIMEOUT_EN
      // A sustained mismatch overrides every other transition and drops all gates at once.
      active = (state == RAMP_UP) || (state == RUN) || (state == RAMP_DOWN);
      if (active && !match) begin
         mm_cnt_n = (mm_cnt == MM_MAX) ? MM_MAX : (mm_cnt + MM_ONE);
      end else begin
         mm_cnt_n = MM_ZERO;
      end
      if (active && (mm_cnt == MM_MAX)) begin
         state_n   = FAULT;
         gate_en_n = EN_ZERO;
         cnt_n     = CNT_ZERO;
      end else begin
         state_n = state_n;
      end
      err_n = (state_n == FAULT);
`else
      err_n = 1'b0;
`endif

      busy_n = (state_n == RAMP_UP) || (state_n == RAMP_DOWN);
      done_n = (state_n == RUN);
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         gate_en <= EN_ZERO;
         cnt     <= CNT_ZERO;
         shift_q <= CNT_ZERO;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         gate_en <= gate_en_n;
         cnt     <= cnt_n;
         shift_q <= shift_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

`ifdef GATE_SYNC_TIMEOUT_EN
   // Consecutive sync-mismatch counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mm_cnt <= MM_ZERO;
      end else begin
         mm_cnt <= mm_cnt_n;
      end
   end
`endif

   assign gate_en_o = gate_en;
   assign busy_o    = busy;
   assign done_o    = done;
   assign err_o     = err;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed self-checking bench for gate_sequencer (N_CH=5, SYNC_TIMEOUT=8).
// Covers both builds; the fault scenario adapts to GATE_SYNC_TIMEOUT_EN.
module tb_gate_sequencer;

   localparam int N_CH  = 5;
   localparam int CNT_W = 32;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] shift;
   logic [N_CH-1:0]  sync_mask;
   logic [N_CH-1:0]  gate_sync;
   logic [N_CH-1:0]  gate_en;
   logic             busy;
   logic             done;
   logic             err;

   int tests_run    = 0;
   int tests_failed = 0;

   gate_sequencer #(
      .N_CH        (N_CH),
      .CNT_W       (CNT_W),
      .SYNC_TIMEOUT(8)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .stop_i     (stop),
      .shift_i    (shift),
      .gate_sync_i(gate_sync),
      .gate_en_o  (gate_en),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   // Loopback feedback with per-bit forcing to 0.
   assign gate_sync = gate_en & ~sync_mask;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N_CH-1:0] therm(input int n);
      logic [N_CH-1:0] ones;
      ones = 5'b11111;
      return ones >> (N_CH - n);
   endfunction

   task automatic go_idle();
      int guard;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      guard = 0;
      while ((busy || done || err) && guard < 64) begin
         tick();
         guard++;
      end
      tests_run++;
      if (busy || done || err || gate_en !== 5'b00000) begin
         tests_failed++;
         $display("FAIL go_idle: busy=%b done=%b err=%b en=%b, required all 0", busy, done, err, gate_en);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: en=%b busy=%b done=%b err=%b, required 00000 0 0 0", gate_en, busy, done, err);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: en=%b busy=%b, required 00000 0", gate_en, busy);
      end
   endtask

   task automatic test_ramp_up();
      logic [N_CH-1:0] exp_en;
      int n;
      shift = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      shift = 32'd0;
      tests_run++;
      if (busy !== 1'b1 || gate_en !== 5'b00000) begin
         tests_failed++;
         $display("FAIL ramp_up_start: busy=%b en=%b, required 1 00000", busy, gate_en);
      end
      for (int e = 1; e <= 22; e++) begin
         tick();
         n = (e / 4 > N_CH) ? N_CH : e / 4;
         exp_en = therm(n);
         tests_run++;
         if (gate_en !== exp_en || busy !== (e < 21) || done !== (e >= 21)) begin
            tests_failed++;
            $display("FAIL ramp_up_e%0d: en=%b busy=%b done=%b, required %b %b %b",
                     e, gate_en, busy, done, exp_en, (e < 21), (e >= 21));
         end
      end
   endtask

   task automatic test_start_in_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tests_run++;
      if (gate_en !== 5'b11111 || done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_in_run: en=%b done=%b busy=%b, required 11111 1 0", gate_en, done, busy);
      end
   endtask

   task automatic test_ramp_down();
      logic [N_CH-1:0] exp_en;
      int n;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         start = (e == 2);
         tick();
         n = (e / 4 > N_CH) ? 0 : N_CH - e / 4;
         exp_en = therm(n);
         tests_run++;
         if (gate_en !== exp_en || busy !== (e <= 20) || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_down_e%0d: en=%b busy=%b done=%b, required %b %b 0",
                     e, gate_en, busy, done, exp_en, (e <= 20));
         end
      end
      start = 1'b0;
   endtask

   task automatic test_stop_partial();
      logic [N_CH-1:0] exp_en;
      shift = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 11; e++) tick();
      // Stop lands on the edge where the third step would otherwise fire.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tests_run++;
      if (gate_en !== 5'b00011 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL stop_priority: en=%b busy=%b, required 00011 1", gate_en, busy);
      end
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp_en = (e < 4) ? 5'b00011 : ((e < 8) ? 5'b00001 : 5'b00000);
         tests_run++;
         if (gate_en !== exp_en || busy !== (e < 9)) begin
            tests_failed++;
            $display("FAIL stop_partial_e%0d: en=%b busy=%b, required %b %b", e, gate_en, busy, exp_en, (e < 9));
         end
      end
   endtask

   task automatic test_sync_stall();
      shift = 32'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tests_run++;
      if (gate_en !== 5'b00011) begin
         tests_failed++;
         $display("FAIL stall_reach: en=%b, required 00011", gate_en);
      end
      sync_mask = 5'b00010;
      for (int e = 1; e <= 5; e++) begin
         tick();
         tests_run++;
         if (gate_en !== 5'b00011 || dut.cnt !== 32'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold_e%0d: en=%b cnt=%0d busy=%b, required 00011 0 1", e, gate_en, dut.cnt, busy);
         end
      end
      sync_mask = 5'b00000;
      for (int e = 1; e <= 4; e++) begin
         tick();
         tests_run++;
         if (gate_en !== therm((e + 2 > N_CH) ? N_CH : e + 2) || done !== (e == 4)) begin
            tests_failed++;
            $display("FAIL stall_resume_e%0d: en=%b done=%b, required %b %b",
                     e, gate_en, done, therm((e + 2 > N_CH) ? N_CH : e + 2), (e == 4));
         end
      end
      go_idle();
   endtask

   task automatic test_timeout();
      shift = 32'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      sync_mask = 5'b00010;
`ifdef GATE_SYNC_TIMEOUT_EN
      for (int e = 1; e <= 8; e++) begin
         tick();
         tests_run++;
         if (gate_en !== 5'b00011 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pre_e%0d: en=%b err=%b, required 00011 0", e, gate_en, err);
         end
      end
      tick();
      tests_run++;
      if (gate_en !== 5'b00000 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_fault: en=%b err=%b busy=%b done=%b, required 00000 1 0 0", gate_en, err, busy, done);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (err !== 1'b1 || busy !== 1'b0 || gate_en !== 5'b00000) begin
         tests_failed++;
         $display("FAIL fault_start_ignored: err=%b busy=%b en=%b, required 1 0 00000", err, busy, gate_en);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      sync_mask = 5'b00000;
      tests_run++;
      if (err !== 1'b0 || busy !== 1'b0 || gate_en !== 5'b00000) begin
         tests_failed++;
         $display("FAIL fault_ack: err=%b busy=%b en=%b, required 0 0 00000", err, busy, gate_en);
      end
`else
      for (int e = 1; e <= 20; e++) tick();
      tests_run++;
      if (gate_en !== 5'b00011 || err !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL stuck_sync_stall: en=%b err=%b busy=%b, required 00011 0 1", gate_en, err, busy);
      end
      sync_mask = 5'b00000;
      go_idle();
`endif
   endtask

   task automatic test_start_stop_idle();
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_stop_idle: en=%b busy=%b done=%b, required 00000 0 0", gate_en, busy, done);
      end
      tick();
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_stop_idle_hold: en=%b busy=%b, required 00000 0", gate_en, busy);
      end
   endtask

   task automatic test_async_reset();
      shift = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 10; e++) tick();
      tests_run++;
      if (gate_en !== 5'b00011) begin
         tests_failed++;
         $display("FAIL async_pre: en=%b, required 00011", gate_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: en=%b busy=%b done=%b err=%b, required 00000 0 0 0", gate_en, busy, done, err);
      end
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      tests_run++;
      if (gate_en !== 5'b00000 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_post: en=%b busy=%b, required 00000 0", gate_en, busy);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      shift     = 32'd0;
      sync_mask = 5'b00000;
      test_reset();
      test_ramp_up();
      test_start_in_run();
      test_ramp_down();
      test_stop_partial();
      test_sync_stall();
      test_timeout();
      test_start_stop_idle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
